// File: rtl/ctr_stream_packer.sv
// Packs the 4-bit iteration-count stream two pixels per byte, tags line/frame
// boundaries and buffers the bytes in a small FIFO behind a valid/ready port.
module ctr_stream_packer #(
  parameter int FIFO_DEPTH = 8,
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          new_ctr,
  input  logic [3:0]                    ctr_in,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_sof,
  output logic                          out_eol,
  output logic                          frame_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [LW-1:0] L_FULL = LW'(FIFO_DEPTH);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [3:0]    nib_q, nib_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          frame_done_q, frame_done_d;

  // Entry layout: {eol, sof, data[7:0]}
  logic [9:0]    mem [FIFO_DEPTH];
  logic [9:0]    head;
  logic [9:0]    wr_entry;
  logic          pix, push, pop, full, push_ok, last_x, last_y, not_empty;

  always_comb begin
    not_empty = (level_q != '0);
    pix       = new_ctr & ~clear;
    last_x    = (x_q == X_LAST);
    last_y    = (y_q == Y_LAST);
    full      = (level_q == L_FULL);
    pop       = not_empty & out_ready;
    push      = pix & x_q[0];
    // A full FIFO can still take the byte when the head leaves this cycle.
    push_ok   = push & (~full | pop);
    wr_entry  = {last_x, (x_q == XW'(1)) && (y_q == '0), ctr_in, nib_q};

    x_d          = x_q;
    y_d          = y_q;
    nib_d        = nib_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    overflow_d   = overflow_q;
    frame_done_d = 1'b0;

    if (clear) begin
      x_d        = '0;
      y_d        = '0;
      nib_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (pix) begin
        if (!x_q[0]) nib_d = ctr_in;
        if (last_x) begin
          x_d = '0;
          y_d = last_y ? '0 : y_q + YW'(1);
        end else begin
          x_d = x_q + XW'(1);
        end
      end
      frame_done_d = pix & last_x & last_y;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(push_ok) - LW'(pop);
      if (push & ~push_ok) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q          <= '0;
      y_q          <= '0;
      nib_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      nib_q        <= nib_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wr_entry;
  end

  // Storage is not reset, so the head is masked while empty to keep outputs at zero.
  assign head       = mem[rd_ptr_q];
  assign out_valid  = not_empty;
  assign out_data   = not_empty ? head[7:0] : 8'h00;
  assign out_sof    = not_empty & head[8];
  assign out_eol    = not_empty & head[9];
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ctr_stream_packer.sv
// Directed bench for ctr_stream_packer with an 8x2 frame and a 4-entry FIFO.
module tb_ctr_stream_packer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       new_ctr = 1'b0;
  logic [3:0] ctr_in = 4'h0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid, out_sof, out_eol, frame_done, overflow;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;

  ctr_stream_packer #(.FIFO_DEPTH(4), .WIDTH(8), .HEIGHT(2)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .new_ctr(new_ctr), .ctr_in(ctr_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eol(out_eol), .frame_done(frame_done),
    .overflow(overflow), .level(level)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic strobe(input logic [3:0] v);
    @(negedge clk);
    new_ctr = 1'b1;
    ctr_in  = v;
    @(negedge clk);
    new_ctr = 1'b0;
  endtask

  task automatic do_clear;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h exp 00", out_data); end
    checks++; if ({out_sof, out_eol} !== 2'b00) begin errors++; $display("FAIL reset_tags: got %b exp 00", {out_sof, out_eol}); end
    checks++; if ({overflow, frame_done} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b exp 00", {overflow, frame_done}); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d exp 0", level); end
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    strobe(4'h3);
    repeat (4) @(negedge clk);
    strobe(4'hA);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b exp 1", out_valid); end
    checks++; if (out_data !== 8'hA3) begin errors++; $display("FAIL basic_data: got %h exp a3", out_data); end
    checks++; if ({out_sof, out_eol} !== 2'b10) begin errors++; $display("FAIL basic_tags: got %b exp 10", {out_sof, out_eol}); end
    @(negedge clk);
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL basic_level_after_pop: got %0d exp 0", level); end
    $display("basic: byte %h sof %b", 8'hA3, 1'b1);
  endtask

  task automatic test_line_end;
    logic [7:0] exp_data;
    do_clear;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      strobe(4'(i));
      if (i % 2 == 1) begin
        exp_data = {4'(i), 4'(i - 1)};
        checks++; if (out_valid !== 1'b1 || out_data !== exp_data) begin errors++; $display("FAIL line_byte%0d: got v%b %h exp v1 %h", i / 2, out_valid, out_data, exp_data); end
        checks++; if (out_sof !== (i == 1)) begin errors++; $display("FAIL line_sof%0d: got %b exp %b", i / 2, out_sof, i == 1); end
        checks++; if (out_eol !== (i == 7 || i == 15)) begin errors++; $display("FAIL line_eol%0d: got %b exp %b", i / 2, out_eol, i == 7 || i == 15); end
        checks++; if (frame_done !== (i == 15)) begin errors++; $display("FAIL line_frame_done%0d: got %b exp %b", i, frame_done, i == 15); end
        $display("line: byte %0d data %h", i / 2, exp_data);
      end
    end
    @(negedge clk);
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL line_frame_done_pulse: got %b exp 0", frame_done); end
  endtask

  task automatic test_overflow;
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h10; exp_q[1] = 8'h32; exp_q[2] = 8'h54; exp_q[3] = 8'h76;
    do_clear;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) strobe(4'(i));
    checks++; if (level !== 3'd4 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_full: got lvl %0d ovf %b exp 4 0", level, overflow); end
    strobe(4'h8);
    strobe(4'h9);
    checks++; if (level !== 3'd4 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_drop: got lvl %0d ovf %b exp 4 1", level, overflow); end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== exp_q[k]) begin errors++; $display("FAIL ovf_drain%0d: got v%b %h exp v1 %h", k, out_valid, out_data, exp_q[k]); end
      checks++; if (out_eol !== (k == 3)) begin errors++; $display("FAIL ovf_eol%0d: got %b exp %b", k, out_eol, k == 3); end
      $display("overflow: drained %h", exp_q[k]);
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_after_drain: got v%b ovf %b exp v0 ovf1", out_valid, overflow); end
    do_clear;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b exp 0", overflow); end
  endtask

  task automatic test_full_pop;
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h32; exp_q[1] = 8'h54; exp_q[2] = 8'h76; exp_q[3] = 8'h98;
    do_clear;
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) strobe(4'(i));
    @(negedge clk);
    new_ctr = 1'b1; ctr_in = 4'h9; out_ready = 1'b1;
    @(negedge clk);
    new_ctr = 1'b0; out_ready = 1'b0;
    checks++; if (level !== 3'd4 || overflow !== 1'b0) begin errors++; $display("FAIL fullpop_level: got lvl %0d ovf %b exp 4 0", level, overflow); end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== exp_q[k]) begin errors++; $display("FAIL fullpop_order%0d: got v%b %h exp v1 %h", k, out_valid, out_data, exp_q[k]); end
      $display("full_pop: drained %h", exp_q[k]);
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fullpop_empty: got %b exp 0", out_valid); end
  endtask

  task automatic test_clear_mid;
    do_clear;
    out_ready = 1'b1;
    strobe(4'h7);
    do_clear;
    strobe(4'h1);
    strobe(4'h2);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h21 || out_sof !== 1'b1) begin errors++; $display("FAIL clear_mid: got v%b %h sof%b exp v1 21 sof1", out_valid, out_data, out_sof); end
    @(negedge clk);
    out_ready = 1'b0;
    strobe(4'h3);
    strobe(4'h4);
    strobe(4'h5);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h43) begin errors++; $display("FAIL rst_pre: got v%b %h exp v1 43", out_valid, out_data); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sof !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL rst_async: got v%b %h sof%b lvl %0d exp all 0", out_valid, out_data, out_sof, level); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    strobe(4'h1);
    strobe(4'h2);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h21 || out_sof !== 1'b1) begin errors++; $display("FAIL rst_mid: got v%b %h sof%b exp v1 21 sof1", out_valid, out_data, out_sof); end
    $display("clear_mid: byte 21 after clear and after reset");
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    do_clear;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) strobe(4'(i));
    for (int c = 0; c < 6; c++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h10 || {out_sof, out_eol} !== 2'b10 || level !== 3'd2) begin errors++; $display("FAIL bp_hold%0d: got v%b %h tags %b lvl %0d exp v1 10 10 2", c, out_valid, out_data, {out_sof, out_eol}, level); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    checks++; if (out_data !== 8'h10) begin errors++; $display("FAIL bp_pop0: got %h exp 10", out_data); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h32 || out_sof !== 1'b0) begin errors++; $display("FAIL bp_pop1: got v%b %h sof%b exp v1 32 sof0", out_valid, out_data, out_sof); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b exp 0", out_valid); end
    $display("backpressure: held 6 cycles then popped 10, 32");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_line_end;
    test_overflow;
    test_full_pop;
    test_clear_mid;
    test_backpressure;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
